// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter that shares one UART transmit byte path
// between NUM_REQ requesters, with an idle-hold timeout and a one-byte output register.
module uart_tx_arbiter #(
  parameter int  NUM_REQ      = 4,
  parameter int  HOLD_TIMEOUT = 1024,
  localparam int IDW          = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic                 timeout
);

  // Handshakes: a byte moves on req_valid[i] & req_ready[i] (requester side) and on
  // out_valid & out_ready (controller side); neither valid may depend on its ready.

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [31:0] HOLD_LIMIT = 32'(HOLD_TIMEOUT - 1);

  state_t         state, state_nx;
  logic [IDW-1:0] grant_nx;
  logic [31:0]    hold_cnt, hold_cnt_nx;
  logic           timeout_nx;

  logic [7:0]     data_arr [NUM_REQ];
  logic [IDW-1:0] winner;
  logic           any_valid;
  logic           g_valid, g_last, slot_free, hs;
  logic [7:0]     g_data;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[8*i +: 8];
    end
  end

  // Scan downward so the lowest offset from grant_id+1 overwrites last and wins.
  always_comb begin
    winner    = grant_id;
    any_valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      logic [IDW-1:0] cand;
      cand = IDW'((int'(grant_id) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
  end

  assign g_valid   = req_valid[grant_id];
  assign g_last    = req_last[grant_id];
  assign g_data    = data_arr[grant_id];
  assign slot_free = !out_valid || out_ready;
  assign hs        = (state == LOCKED) && g_valid && slot_free;
  assign busy      = (state == LOCKED);

  always_comb begin
    req_ready = '0;
    if (state == LOCKED) begin
      req_ready[grant_id] = slot_free;
    end
  end

  always_comb begin
    state_nx    = state;
    grant_nx    = grant_id;
    hold_cnt_nx = hold_cnt;
    timeout_nx  = 1'b0;
    case (state)
      IDLE: begin
        hold_cnt_nx = '0;
        if (any_valid) begin
          state_nx = LOCKED;
          grant_nx = winner;
        end
      end
      LOCKED: begin
        if (hs) begin
          hold_cnt_nx = '0;
          if (g_last) begin
            state_nx = IDLE;
          end
        end else if (HOLD_TIMEOUT != 0) begin
          // The held output byte is left alone on a forced release and still drains.
          if (hold_cnt == HOLD_LIMIT) begin
            state_nx   = IDLE;
            timeout_nx = 1'b1;
          end else if (hold_cnt != 32'hFFFF_FFFF) begin
            hold_cnt_nx = hold_cnt + 32'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      grant_id <= IDW'(NUM_REQ - 1);
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nx;
      grant_id <= grant_nx;
      hold_cnt <= hold_cnt_nx;
      timeout  <= timeout_nx;
    end
  end

  // Drain and refill may coincide, sustaining one byte per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (hs) begin
      out_valid <= 1'b1;
      out_data  <= g_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table vectors, directed multi-cycle sequences and a
// randomized run checked against a cycle-level behavioural model with a byte scoreboard.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0] req_last;
  logic [N-1:0] req_ready;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   grant_id;
  logic         busy;
  logic         timeout;

  uart_tx_arbiter #(.NUM_REQ(N), .HOLD_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .grant_id(grant_id),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // Model: who owns the path, how long it has stalled, and the output register.
  bit         m_locked;
  int         m_gid;
  int         m_stall;
  bit         m_ov;
  logic [7:0] m_od;
  bit         m_to;
  int         hs_idx;
  bit         hs_last;

  typedef struct {
    logic [3:0]  rv;
    logic [31:0] rd;
    logic [3:0]  rl;
    logic        ordy;
    logic [3:0]  e_ready;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [1:0]  e_gid;
    logic        e_busy;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic [3:0] rv, logic [31:0] rd, logic [3:0] rl, logic ordy,
                              logic [3:0] e_ready, logic e_ov, logic [7:0] e_od,
                              logic [1:0] e_gid, logic e_busy);
    vec_t v;
    v.rv = rv; v.rd = rd; v.rl = rl; v.ordy = ordy;
    v.e_ready = e_ready; v.e_ov = e_ov; v.e_od = e_od; v.e_gid = e_gid; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_gid = N - 1; m_stall = 0; m_ov = 0; m_od = 8'h00; m_to = 0;
    exp_q.delete();
  endtask

  task automatic set_inputs(input logic [3:0] rv, input logic [31:0] rd,
                            input logic [3:0] rl, input logic ordy);
    req_valid = rv; req_data = rd; req_last = rl; out_ready = ordy;
  endtask

  // Called in the low clock phase with inputs applied; checks, advances model, moves one cycle.
  task automatic step();
    logic [N-1:0] exp_ready;
    bit hs;
    int w;
    #1;
    exp_ready = '0;
    if (m_locked && (!m_ov || out_ready)) exp_ready[m_gid] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) chk("out_data", 32'(out_data), 32'(m_od));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("busy", 32'(busy), 32'(m_locked));
    chk("timeout", 32'(timeout), 32'(m_to));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_extra_byte: got %0h expected none", out_data);
      end else begin
        chk("sb_byte", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
    hs = m_locked && req_valid[m_gid] && (!m_ov || out_ready);
    hs_idx = hs ? m_gid : -1;
    hs_last = hs && req_last[m_gid];
    if (hs) begin
      m_od = 8'(req_data >> (8 * m_gid));
      m_ov = 1;
      exp_q.push_back(m_od);
    end else if (m_ov && out_ready) begin
      m_ov = 0;
    end
    m_to = 0;
    if (!m_locked) begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        if (w < 0 && req_valid[(m_gid + k) % N]) w = (m_gid + k) % N;
      end
      if (w >= 0) begin m_locked = 1; m_gid = w; m_stall = 0; end
    end else if (hs) begin
      m_stall = 0;
      if (hs_last) m_locked = 0;
    end else if (TO != 0) begin
      m_stall++;
      if (m_stall == TO) begin m_locked = 0; m_to = 1; end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_inputs(4'h0, 32'h0, 4'h0, 1'b0);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'(N - 1));
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int to_cyc, to_cnt, g_cyc, cnt[N], order[$], last_end, gaps_bad;
    logic [31:0] rd;
    logic busy10;
    int pct;

    vecs[0]  = mk(4'h1, 32'h41,   4'h0, 1, 4'h0, 0, 8'h00, 2'd3, 0);
    vecs[1]  = mk(4'h1, 32'h41,   4'h0, 1, 4'h1, 0, 8'h00, 2'd0, 1);
    vecs[2]  = mk(4'h1, 32'h42,   4'h0, 1, 4'h1, 1, 8'h41, 2'd0, 1);
    vecs[3]  = mk(4'h1, 32'h43,   4'h1, 1, 4'h1, 1, 8'h42, 2'd0, 1);
    vecs[4]  = mk(4'h0, 32'h0,    4'h0, 1, 4'h0, 1, 8'h43, 2'd0, 0);
    vecs[5]  = mk(4'h0, 32'h0,    4'h0, 1, 4'h0, 0, 8'h43, 2'd0, 0);
    vecs[6]  = mk(4'h2, 32'h5100, 4'h0, 0, 4'h0, 0, 8'h43, 2'd0, 0);
    vecs[7]  = mk(4'h2, 32'h5100, 4'h0, 0, 4'h2, 0, 8'h43, 2'd1, 1);
    for (int i = 8; i <= 12; i++) vecs[i] = mk(4'h2, 32'h5200, 4'h0, 0, 4'h0, 1, 8'h51, 2'd1, 1);
    vecs[13] = mk(4'h2, 32'h5200, 4'h2, 1, 4'h2, 1, 8'h51, 2'd1, 1);
    vecs[14] = mk(4'h0, 32'h0,    4'h0, 1, 4'h0, 1, 8'h52, 2'd1, 0);
    vecs[15] = mk(4'h0, 32'h0,    4'h0, 1, 4'h0, 0, 8'h52, 2'd1, 0);

    reset = 1'b0;
    set_inputs(4'h0, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    do_reset();

    // Single message at full rate, then a 5-cycle controller stall.
    for (int i = 0; i < 16; i++) begin
      set_inputs(vecs[i].rv, vecs[i].rd, vecs[i].rl, vecs[i].ordy);
      #1;
      chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].e_od));
      chk($sformatf("vec%0d_grant_id", i), 32'(grant_id), 32'(vecs[i].e_gid));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d_timeout", i), 32'(timeout), 32'h0);
      step();
    end

    // All four contend with 2-byte messages: rotation 0,1,2,3,0 with one idle cycle between.
    do_reset();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    last_end = -1; gaps_bad = 0;
    for (int c = 0; c < 16; c++) begin
      rd = 32'h0;
      for (int i = 0; i < N; i++) rd = rd | (32'({i[3:0], 4'(cnt[i])}) << (8 * i));
      set_inputs(4'hF, rd, {4'(cnt[3] % 2 == 1), 4'h0} >> 4 |
                 {1'b0, 1'b0, 1'b0, 1'b0} | 4'({cnt[3][0], cnt[2][0], cnt[1][0], cnt[0][0]}), 1'b1);
      step();
      if (hs_idx >= 0) begin
        if (cnt[hs_idx] % 2 == 0) begin
          order.push_back(hs_idx);
          if (last_end >= 0 && c - last_end != 2) gaps_bad++;
        end
        if (hs_last) last_end = c;
        cnt[hs_idx]++;
      end
    end
    chk("t2_msgs", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5 && i < order.size(); i++)
      chk($sformatf("t2_order%0d", i), 32'(order[i]), 32'(i % N));
    chk("t2_bubble", 32'(gaps_bad), 32'd0);

    // Owner stalls after one byte: forced release, then requester 2 takes over.
    do_reset();
    to_cyc = -1; to_cnt = 0; g_cyc = -1;
    for (int c = 0; c < 14; c++) begin
      if (c < 2) set_inputs(4'h1, 32'h61, 4'h0, 1'b1);
      else       set_inputs(4'h4, 32'h0071_0000, 4'h4, 1'b1);
      #1;
      if (timeout) begin to_cnt++; if (to_cyc < 0) to_cyc = c; end
      if (busy && grant_id == 2'd2 && g_cyc < 0) g_cyc = c;
      step();
    end
    chk("t3_timeout_cycle", 32'(to_cyc), 32'd10);
    chk("t3_timeout_width", 32'(to_cnt), 32'd1);
    chk("t3_next_grant_cycle", 32'(g_cyc), 32'd11);

    // Handshake lands on the timeout cycle: lock kept, counter restarts.
    do_reset();
    to_cyc = -1; busy10 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c < 2)       set_inputs(4'h1, 32'h81, 4'h0, 1'b1);
      else if (c == 9) set_inputs(4'h1, 32'h82, 4'h0, 1'b1);
      else             set_inputs(4'h0, 32'h0, 4'h0, 1'b1);
      #1;
      if (timeout && to_cyc < 0) to_cyc = c;
      if (c == 10) busy10 = busy;
      step();
    end
    chk("t6_busy_after_hs", 32'(busy10), 32'd1);
    chk("t6_timeout_cycle", 32'(to_cyc), 32'd18);

    // Reset while a byte is held: nothing replayed, requester 0 first afterwards.
    do_reset();
    set_inputs(4'h1, 32'h91, 4'h0, 1'b0); step();
    set_inputs(4'h1, 32'h91, 4'h0, 1'b0); step();
    set_inputs(4'h1, 32'h92, 4'h0, 1'b0); #1;
    chk("t5_held_valid", 32'(out_valid), 32'd1);
    do_reset();
    g_cyc = -1;
    for (int c = 0; c < 4; c++) begin
      set_inputs(4'h9, 32'hB300_00A0, 4'h9, 1'b1);
      #1;
      if (busy && g_cyc < 0) g_cyc = int'(grant_id);
      step();
    end
    chk("t5_grant_after_reset", 32'(g_cyc), 32'd0);

    // Randomized traffic with varying requester activity and occasional reset.
    do_reset();
    pct = 80;
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] rv, rl;
      if (c % 150 == 0) pct = ($urandom_range(0, 2) == 0) ? 15 : 85;
      if ($urandom_range(0, 499) == 0) do_reset();
      for (int i = 0; i < N; i++) begin
        rv[i] = ($urandom_range(0, 99) < pct);
        rl[i] = ($urandom_range(0, 3) == 0);
      end
      set_inputs(rv, $urandom, rl, ($urandom_range(0, 9) < 7));
      step();
    end
    set_inputs(4'h0, 32'h0, 4'h0, 1'b1);
    for (int c = 0; c < 3; c++) step();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
